qsys_clkdiv_gen: RTL and testbench
==================================

Name: qsys_clkdiv_gen

Overview:
Parametrised multi-channel clock-divider generator running on the system reference clock. It produces NUM_CLOCKS registered divided clocks plus one-cycle enable strobes, each with a runtime-programmable divide ratio and phase offset, and a `locked` indication. It is the next-generation clock source for the Qsys subsystem. Where a fixed-ratio clock plan is not needed, logic uses its strobes as clock enables, and fabric-only blocks may use its divided clocks directly.

Parameters:
NUM_CLOCKS, 5, number of output channels (1..16)
DIV_W, 8, width of the divide-ratio and phase fields
CH_W, 3, width of the channel select; must satisfy 2^CH_W >= NUM_CLOCKS
DIV_INIT, {5{8'd2}}, packed per-channel reset divide ratios; channel i is at bits [i*DIV_W +: DIV_W]
PHASE_INIT, all zero, packed per-channel reset phase offsets, same packing as DIV_INIT
LOCK_DELAY, 16, cycles from counter start to `locked` assertion (>=1)

Ports:
refclk  in  1  sole clock; all logic is on its rising edge
rst_n  in  1  synchronous active-low reset
cfg_wr  in  1  write pulse into the shadow registers
cfg_chan  in  CH_W  channel index for cfg_wr
cfg_div  in  DIV_W  divide ratio to write
cfg_phase  in  DIV_W  phase offset to write
cfg_apply  in  1  pulse: copy shadow to active and realign all channels
outclk  out  NUM_CLOCKS  divided clocks
outen  out  NUM_CLOCKS  one-cycle strobes, one per divided-clock period
locked  out  1  all channels aligned and stable

Behaviour:
- Reset (rst_n=0 at an edge):
  - shadow and active registers load DIV_INIT/PHASE_INIT.
  - state=LOAD; outclk=0, outen=0, locked=0.
- State machine:
  - LOAD: 1 cycle; each counter cnt_i loads start value (N_i-P_i) mod N_i; outputs forced 0. Next state WAIT_LOCK.
  - WAIT_LOCK: counters run; lock counter counts to LOCK_DELAY; on reaching it, go to LOCKED.
  - LOCKED: counters run; locked=1.
  - cfg_apply=1 in any state (rst_n=1): active registers <= shadow registers, next state LOAD, so locked=0 from the next cycle.
- Timing: cfg_apply sampled at edge t gives LOAD during cycle t+1. Counters run from edge t+2. locked=1 from edge t+1+LOCK_DELAY.
  - Example: LOCK_DELAY=16 and apply at edge 10 gives locked high after edge 27.
- Counter rule (N=active div, P=active phase): cnt_i wraps N-1 -> 0, otherwise increments.
- Output rule (registered, valid in WAIT_LOCK and LOCKED):
  - outen_i=1 when cnt_i==0.
  - N>=2: outclk_i=1 when cnt_i < (N>>1). Gives 50% duty for even N; for odd N, high for floor(N/2) cycles.
  - N=1: outclk_i held 1 and outen_i=1 every cycle.
  - N=0: channel disabled; outclk_i=0, outen_i=0, counter held at 0. It does not block locked.
- Phase: P>=N is clamped to N-1 when copied to the active registers. The first outen_i occurs P cycles after the counters start. Channels with equal N and P stay cycle-aligned indefinitely.
- Writes:
  - cfg_wr updates the shadow registers only; active behaviour is unchanged until cfg_apply.
  - cfg_chan >= NUM_CLOCKS: the write is ignored.
  - cfg_wr and cfg_apply in the same cycle: the write lands in shadow first, and apply copies the updated value.
- Reset has priority over cfg_wr and cfg_apply. Reset mid-WAIT_LOCK or mid-LOCKED discards shadow edits and restores the INIT values.
- No combinational path from inputs to outputs.

Test Plan:
- Reset defaults (5 ch, div 2, phase 0, LOCK_DELAY 16):
  - release rst_n -> all outclk toggle 1,0 with period 2, strobes aligned;
  - locked rises on the 17th edge after LOAD.
- Program ch0 div=3 phase=0, ch1 div=4 phase=1, then apply:
  - locked drops the next cycle;
  - ch0 period 3, high 1 cycle;
  - ch1 period 4, high 2 cycles, first outen 1 cycle after ch0's first outen.
- Write ch2 div=6 with no apply:
  - outputs unchanged for 100 cycles;
  - apply -> ch2 period 6, high 3.
- Boundary values:
  - div=0 on ch3 -> outclk3/outen3 stay 0 and locked still asserts;
  - div=1 on ch4 -> outclk4=1 and outen4=1 every cycle;
  - phase=9 with div=4 -> behaves as phase 3.
- cfg_wr plus cfg_apply in the same cycle (ch0 div=8) -> new ratio takes effect.
- cfg_chan=7 write -> no register changes.
- Assert rst_n low during WAIT_LOCK after an edited apply -> INIT ratios restored and the lock sequence restarts.

Source files
------------

// File: rtl/qsys_clkdiv_gen.sv
// Multi-channel clock divider on refclk: programmable ratio/phase per channel,
// shadow/active register pair, realignment on apply and a lock indication.
module qsys_clkdiv_gen #(
  parameter int NUM_CLOCKS = 5,
  parameter int DIV_W = 8,
  parameter int CH_W = 3,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_INIT = {NUM_CLOCKS{DIV_W'(2)}},
  parameter logic [NUM_CLOCKS*DIV_W-1:0] PHASE_INIT = '0,
  parameter int LOCK_DELAY = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  input  logic                  cfg_apply,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outen,
  output logic                  locked
);

  localparam int LW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [DIV_W-1:0] shadow_div_r [NUM_CLOCKS];
  logic [DIV_W-1:0] shadow_ph_r  [NUM_CLOCKS];
  logic [DIV_W-1:0] shadow_div_s [NUM_CLOCKS];
  logic [DIV_W-1:0] shadow_ph_s  [NUM_CLOCKS];
  logic [DIV_W-1:0] act_div_r    [NUM_CLOCKS];
  logic [DIV_W-1:0] act_ph_r     [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt_r        [NUM_CLOCKS];
  logic [DIV_W-1:0] cnt_s        [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] outclk_r, outclk_s;
  logic [NUM_CLOCKS-1:0] outen_r, outen_s;
  logic [LW-1:0]         lock_cnt_r, lock_cnt_s;
  logic                  locked_r;

  // A phase at or beyond the ratio is pulled back to the last slot of the period.
  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] phase);
    logic [DIV_W-1:0] res;
    if (div == '0) begin
      res = '0;
    end else if (phase >= div) begin
      res = div - DIV_W'(1);
    end else begin
      res = phase;
    end
    return res;
  endfunction

  function automatic logic [DIV_W-1:0] start_count(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] phase);
    logic [DIV_W-1:0] res;
    if (phase == '0) begin
      res = '0;
    end else begin
      res = div - phase;
    end
    return res;
  endfunction

  // Shadow next value: a write lands before a same-cycle apply copies it.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (cfg_wr && (cfg_chan == CH_W'(i))) begin
        shadow_div_s[i] = cfg_div;
        shadow_ph_s[i]  = cfg_phase;
      end else begin
        shadow_div_s[i] = shadow_div_r[i];
        shadow_ph_s[i]  = shadow_ph_r[i];
      end
    end
  end

  // Next-state logic; apply forces a realignment from any state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD:      state_s = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_cnt_r == LW'(LOCK_DELAY - 1)) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_WAIT_LOCK;
        end
      end
      ST_LOCKED:    state_s = ST_LOCKED;
      default:      state_s = ST_LOAD;
    endcase
    if (cfg_apply) begin
      state_s = ST_LOAD;
    end else begin
      state_s = state_s;
    end
  end

  // Counter, lock-timer and per-channel output next values.
  always_comb begin
    lock_cnt_s = lock_cnt_r;
    outclk_s   = '0;
    outen_s    = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      cnt_s[i] = cnt_r[i];
    end
    if (cfg_apply) begin
      lock_cnt_s = '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          lock_cnt_s = '0;
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_s[i] = start_count(act_div_r[i], act_ph_r[i]);
          end
        end
        ST_WAIT_LOCK, ST_LOCKED: begin
          if ((state_r == ST_WAIT_LOCK) && (lock_cnt_r != LW'(LOCK_DELAY - 1))) begin
            lock_cnt_s = lock_cnt_r + LW'(1);
          end else begin
            lock_cnt_s = lock_cnt_r;
          end
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (act_div_r[i] == '0) begin
              cnt_s[i] = '0;
            end else begin
              outen_s[i] = (cnt_r[i] == '0);
              if (act_div_r[i] == DIV_W'(1)) begin
                outclk_s[i] = 1'b1;
              end else begin
                outclk_s[i] = (cnt_r[i] < (act_div_r[i] >> 1));
              end
              if (cnt_r[i] >= (act_div_r[i] - DIV_W'(1))) begin
                cnt_s[i] = '0;
              end else begin
                cnt_s[i] = cnt_r[i] + DIV_W'(1);
              end
            end
          end
        end
        default: lock_cnt_s = '0;
      endcase
    end
  end

  // State register and registered lock flag.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_r  <= ST_LOAD;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      locked_r <= (state_s == ST_LOCKED);
    end
  end

  // Configuration registers: shadow every cycle, active only on apply.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        shadow_div_r[i] <= DIV_INIT[i*DIV_W +: DIV_W];
        shadow_ph_r[i]  <= PHASE_INIT[i*DIV_W +: DIV_W];
        act_div_r[i]    <= DIV_INIT[i*DIV_W +: DIV_W];
        act_ph_r[i]     <= clamp_phase(DIV_INIT[i*DIV_W +: DIV_W], PHASE_INIT[i*DIV_W +: DIV_W]);
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        shadow_div_r[i] <= shadow_div_s[i];
        shadow_ph_r[i]  <= shadow_ph_s[i];
        if (cfg_apply) begin
          act_div_r[i] <= shadow_div_s[i];
          act_ph_r[i]  <= clamp_phase(shadow_div_s[i], shadow_ph_s[i]);
        end else begin
          act_div_r[i] <= act_div_r[i];
          act_ph_r[i]  <= act_ph_r[i];
        end
      end
    end
  end

  // Channel counters, lock timer and output registers.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt_r[i] <= '0;
      end
      outclk_r   <= '0;
      outen_r    <= '0;
      lock_cnt_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
      outclk_r   <= outclk_s;
      outen_r    <= outen_s;
      lock_cnt_r <= lock_cnt_s;
    end
  end

  assign outclk = outclk_r;
  assign outen  = outen_r;
  assign locked = locked_r;

endmodule

// File: tb/tb_qsys_clkdiv_gen.sv
// Bench for qsys_clkdiv_gen: directed and random configuration sequences checked
// every cycle against a time-based reference model of each channel's waveform.
module tb_qsys_clkdiv_gen;

  localparam int NC = 5;
  localparam int LD = 16;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       cfg_wr;
  logic [2:0] cfg_chan;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic       cfg_apply;
  logic [4:0] outclk;
  logic [4:0] outen;
  logic       locked;

  int    n_assert = 0;
  int    n_fail = 0;
  int    edge_no = 0;
  int    m_start = 0;
  int    m_sdiv [NC];
  int    m_sph  [NC];
  int    m_adiv [NC];
  int    m_aph  [NC];
  string phase_name = "reset";

  qsys_clkdiv_gen #(
    .NUM_CLOCKS(5), .DIV_W(8), .CH_W(3),
    .DIV_INIT({5{8'd2}}), .PHASE_INIT(40'd0), .LOCK_DELAY(LD)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_apply(cfg_apply),
    .outclk(outclk), .outen(outen), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s:%s observed=%0h expected=%0h (edge %0d)", phase_name, tag, obs, exp, edge_no);
    end
  endtask

  // One clock edge: update the model from the inputs sampled at that edge, then compare.
  task automatic step();
    logic [4:0] e_clk;
    logic [4:0] e_en;
    logic       e_lk;
    int k, n, p, pos;
    @(posedge refclk);
    #1;
    edge_no++;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_sdiv[i] = 2; m_sph[i] = 0; m_adiv[i] = 2; m_aph[i] = 0;
      end
      m_start = edge_no + 2;
    end else begin
      if (cfg_wr && (int'(cfg_chan) < NC)) begin
        m_sdiv[int'(cfg_chan)] = int'(cfg_div);
        m_sph[int'(cfg_chan)]  = int'(cfg_phase);
      end
      if (cfg_apply) begin
        for (int i = 0; i < NC; i++) begin
          m_adiv[i] = m_sdiv[i];
          m_aph[i]  = (m_sdiv[i] > 0 && m_sph[i] >= m_sdiv[i]) ? m_sdiv[i] - 1 : m_sph[i];
        end
        m_start = edge_no + 2;
      end
    end
    e_clk = '0;
    e_en  = '0;
    e_lk  = 1'b0;
    if (edge_no >= m_start) begin
      k = edge_no - m_start;
      for (int i = 0; i < NC; i++) begin
        n = m_adiv[i];
        p = m_aph[i];
        if (n == 1) begin
          e_clk[i] = 1'b1;
          e_en[i]  = 1'b1;
        end else if (n >= 2) begin
          pos = (k + n - p) % n;
          e_en[i]  = (pos == 0);
          e_clk[i] = (pos < n / 2);
        end
      end
      e_lk = (edge_no >= m_start + LD - 1);
    end
    check("outclk", 32'(outclk), 32'(e_clk));
    check("outen", 32'(outen), 32'(e_en));
    check("locked", 32'(locked), 32'(e_lk));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int ch, input int dv, input int ph, input logic ap);
    cfg_wr    = 1'b1;
    cfg_chan  = 3'(ch);
    cfg_div   = 8'(dv);
    cfg_phase = 8'(ph);
    cfg_apply = ap;
    step();
    cfg_wr    = 1'b0;
    cfg_apply = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    step();
    cfg_apply = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_chan = 3'd0;
    cfg_div = 8'd0; cfg_phase = 8'd0; cfg_apply = 1'b0;
    run(3);
    phase_name = "defaults";
    rst_n = 1'b1;
    run(40);

    phase_name = "div3_div4ph1";
    wr(0, 3, 0, 1'b0);
    wr(1, 4, 1, 1'b0);
    apply();
    run(40);

    phase_name = "shadow_only";
    wr(2, 6, 0, 1'b0);
    run(100);
    phase_name = "ch2_div6";
    apply();
    run(40);

    phase_name = "boundary";
    wr(3, 0, 0, 1'b0);
    wr(4, 1, 0, 1'b0);
    wr(1, 4, 9, 1'b0);
    apply();
    run(40);

    phase_name = "wr_apply_same";
    wr(0, 8, 0, 1'b1);
    run(30);

    phase_name = "bad_chan";
    wr(7, 5, 2, 1'b0);
    run(20);
    apply();
    run(30);

    phase_name = "reset_in_wait";
    wr(0, 5, 3, 1'b1);
    run(5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(40);

    phase_name = "random";
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
         int'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
      run(int'($urandom_range(1, 40)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
